ss_wb_arb: RTL
==============

Name: ss_wb_arb

Overview:
- Two-master Wishbone arbiter that shares the single DMA system-bus port between the source scatter-gather engine (m0, read side) and the destination scatter-gather engine (m1, write side).
- It sits between the two SG engines and the bus slave interface.
- Grants are held for a whole cycle (cyc high). Arbitration is round-robin.
- An optional beat limit forces a long burst to yield by returning retry. The SG engines already handle retry by dropping cyc and re-requesting.

Parameters:
- MAX_BEATS, 16: acks allowed per grant before forced yield. Legal range 1..255. Used only with SS_ARB_BEAT_LIMIT_EN.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- mN_cyc, mN_stb, mN_we, mN_cab  in  1 each  master N bus controls (N=0,1).
- mN_sel  in  4  master N byte select.
- mN_adr  in  32  master N address.
- mN_dat_i, mN_dat64_i  in  32 each  master N write data, low/high word.
- mN_dat_o, mN_dat64_o  out  32 each  read data to master N.
- mN_ack, mN_rty, mN_err  out  1 each  termination to master N.
- wbs_cyc, wbs_stb, wbs_we, wbs_cab  out  1 each  to slave.
- wbs_sel  out  4  to slave.
- wbs_adr  out  32  to slave.
- wbs_dat_i, wbs_dat64_i  out  32 each  write data to slave.
- wbs_dat_o, wbs_dat64_o  in  32 each  read data from slave.
- wbs_ack, wbs_rty, wbs_err  in  1 each  slave termination.
- arb_gnt  out  2  one-hot current owner ({m1,m0}); 2'b00 when idle.
- arb_busy  out  1  a grant is active.

Behaviour:
- States: S_IDLE, S_GNT0, S_GNT1. State is registered. Reset (synchronous) forces S_IDLE, last_gnt=1, beat_cnt=0.
- Reset values: all slave outputs 0, all master terminations 0, arb_gnt=0, arb_busy=0.
- Reset asserted mid-burst:
  - Next edge goes to S_IDLE.
  - Slave cyc/stb drop in the same cycle the state leaves the grant state.
  - No pending ack is forwarded afterwards.
- Transitions out of S_IDLE:
  - Only m0_cyc: go to S_GNT0.
  - Only m1_cyc: go to S_GNT1.
  - Both: grant the master not equal to last_gnt.
  - Entering a grant state updates last_gnt and clears beat_cnt.
- Latency: a request sampled in S_IDLE at edge N is granted and drives the slave from cycle N+1. Minimum 1 cycle arbitration latency.
- While in S_GNTn:
  - Slave outputs (cyc, stb, we, cab, sel, adr, dat_i, dat64_i) are a combinational mux of master n.
  - Master n's terminations are a combinational mux of slave ack/rty/err.
  - The non-owner sees ack/rty/err = 0.
  - wbs_dat_o and wbs_dat64_o are broadcast to both masters.
- Grant release:
  - When the owner deasserts cyc, the next state is the other master's grant if its cyc is high, otherwise S_IDLE.
  - The owner cannot be re-granted back-to-back if the other master is waiting.
- In S_IDLE: wbs_cyc=wbs_stb=0 and all master terminations are 0.
- beat_cnt: 8 bits. Increments on wbs_ack during a grant and saturates at 255. err and rty do not count.
- err from the slave is forwarded unmodified. The arbiter does not change state until the owner drops cyc.
- Simultaneous owner release and other-master request in the same cycle: handoff with no idle cycle.
- arb_gnt and arb_busy are decoded from the registered state (glitch-free).

Optional Feature:
- Macro: SS_ARB_BEAT_LIMIT_EN.
- Defined: forced yield.
  - Condition: in S_GNTn, beat_cnt >= MAX_BEATS and the other master's cyc is high.
  - Action: wbs_stb is forced to 0 and master n receives mN_rty=1 every cycle (ack/err masked) until mN_cyc drops.
  - Handoff to the other master then follows the normal release rule.
  - If the other master is not requesting, no forced yield occurs.
- Undefined: grants are held until voluntary cyc release. The beat_cnt logic may be omitted, and rty is only slave rty.

Test Plan:
- m0 alone, 4-beat burst, slave acks every cycle -> arb_gnt=01 one cycle after m0_cyc; m0_ack=4 pulses; m1_ack=0; S_IDLE one cycle after m0_cyc falls.
- m0 and m1 raise cyc in the same cycle after reset -> m0 granted first (last_gnt=1); on m0 release, m1 granted with zero idle cycles; next simultaneous request grants m0.
- m1 owns the bus and slave returns wbs_err on beat 2 -> m1_err=1 that cycle, m0 sees 0; grant held until m1_cyc drops.
- With SS_ARB_BEAT_LIMIT_EN, MAX_BEATS=4, m0 runs a 10-beat burst while m1 requests -> after 4 acks wbs_stb=0 and m0_rty=1; m0 drops cyc, then arb_gnt=10.
- Same stimulus as the previous scenario but m1 idle -> m0 completes all 10 beats with no rty.
- wb_rst_i asserted for 1 cycle mid-burst in S_GNT1 -> next cycle wbs_cyc=0, arb_gnt=00, arb_busy=0, and m1_ack is not forwarded.

Source files
------------

// File: rtl/ss_wb_arb.sv
// Two-master round-robin Wishbone arbiter sharing the DMA system-bus port.
// Optional forced yield after MAX_BEATS acks is enabled by SS_ARB_BEAT_LIMIT_EN.
module ss_wb_arb #(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic        m0_cab,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_dat64_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m0_dat64_o,
  output logic        m0_ack,
  output logic        m0_rty,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic        m1_cab,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_dat64_i,
  output logic [31:0] m1_dat_o,
  output logic [31:0] m1_dat64_o,
  output logic        m1_ack,
  output logic        m1_rty,
  output logic        m1_err,
  output logic        wbs_cyc,
  output logic        wbs_stb,
  output logic        wbs_we,
  output logic        wbs_cab,
  output logic [3:0]  wbs_sel,
  output logic [31:0] wbs_adr,
  output logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat64_i,
  input  logic [31:0] wbs_dat_o,
  input  logic [31:0] wbs_dat64_o,
  input  logic        wbs_ack,
  input  logic        wbs_rty,
  input  logic        wbs_err,
  output logic [1:0]  arb_gnt,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_e;

`ifdef SS_ARB_BEAT_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif
  localparam logic [7:0] MAX_BEATS_8 = 8'(MAX_BEATS);

  state_e     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;   // 1 = m1 was the most recent owner
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       owner_cyc, other_cyc, yield;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    owner_cyc = 1'b0;
    other_cyc = 1'b0;
    case (state_q)
      S_GNT0: begin owner_cyc = m0_cyc; other_cyc = m1_cyc; end
      S_GNT1: begin owner_cyc = m1_cyc; other_cyc = m0_cyc; end
      default: ;
    endcase
    // Only yield when someone is actually waiting for the bus.
    yield = LIMIT_EN && owner_cyc && other_cyc && (beat_cnt_q >= MAX_BEATS_8);
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q != S_IDLE && wbs_ack && beat_cnt_q != 8'hFF)
      beat_cnt_d = beat_cnt_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_gnt_q ? S_GNT0 : S_GNT1;
        else if (m0_cyc)      state_d = S_GNT0;
        else if (m1_cyc)      state_d = S_GNT1;
      end
      S_GNT0: if (!m0_cyc) state_d = m1_cyc ? S_GNT1 : S_IDLE;
      S_GNT1: if (!m1_cyc) state_d = m0_cyc ? S_GNT0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q && state_d != S_IDLE) begin
      last_gnt_d = (state_d == S_GNT1);
      beat_cnt_d = 8'd0;
    end
  end

  always_comb begin
    wbs_cyc     = 1'b0;
    wbs_stb     = 1'b0;
    wbs_we      = 1'b0;
    wbs_cab     = 1'b0;
    wbs_sel     = 4'd0;
    wbs_adr     = 32'd0;
    wbs_dat_i   = 32'd0;
    wbs_dat64_i = 32'd0;
    m0_ack      = 1'b0;
    m0_rty      = 1'b0;
    m0_err      = 1'b0;
    m1_ack      = 1'b0;
    m1_rty      = 1'b0;
    m1_err      = 1'b0;
    case (state_q)
      S_GNT0: begin
        wbs_cyc     = m0_cyc;
        wbs_stb     = m0_stb & ~yield;
        wbs_we      = m0_we;
        wbs_cab     = m0_cab;
        wbs_sel     = m0_sel;
        wbs_adr     = m0_adr;
        wbs_dat_i   = m0_dat_i;
        wbs_dat64_i = m0_dat64_i;
        m0_ack      = wbs_ack & ~yield;
        m0_err      = wbs_err & ~yield;
        m0_rty      = wbs_rty | yield;
      end
      S_GNT1: begin
        wbs_cyc     = m1_cyc;
        wbs_stb     = m1_stb & ~yield;
        wbs_we      = m1_we;
        wbs_cab     = m1_cab;
        wbs_sel     = m1_sel;
        wbs_adr     = m1_adr;
        wbs_dat_i   = m1_dat_i;
        wbs_dat64_i = m1_dat64_i;
        m1_ack      = wbs_ack & ~yield;
        m1_err      = wbs_err & ~yield;
        m1_rty      = wbs_rty | yield;
      end
      default: ;
    endcase
  end

  assign m0_dat_o   = wbs_dat_o;
  assign m0_dat64_o = wbs_dat64_o;
  assign m1_dat_o   = wbs_dat_o;
  assign m1_dat64_o = wbs_dat64_o;

  assign arb_gnt  = {state_q == S_GNT1, state_q == S_GNT0};
  assign arb_busy = (state_q != S_IDLE);

endmodule
